// File: rtl/sum_acc_pkg.sv
// sum_acc shared types and default sizing.
// FSM state encoding and datapath widths for the burst accumulator.
package sum_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int DATA_W = 6;
    localparam int COUNT  = 8;
    localparam int ACC_W  = 8;

endpackage

// File: rtl/sum_acc_ctrl.sv
// sum_acc control: burst FSM and result counter.
// Produces the handshakes and the accept/load/done strobes for the datapath.
module sum_acc_ctrl #(
    parameter int COUNT = sum_acc_pkg::COUNT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic out_valid,
    output logic accept,
    output logic load,
    output logic done
);
    import sum_acc_pkg::*;

    localparam int CNT_W = $clog2(COUNT);

    state_t state;
    state_t state_nxt;
    logic [CNT_W-1:0] cnt;
    logic at_last;

    assign at_last = (cnt == CNT_W'(COUNT - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: clear always returns to ACCUM
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ACCUM;
        end else begin
            unique case (state)
                ACCUM: if (load) state_nxt = HOLD;
                HOLD:  if (out_ready) state_nxt = ACCUM;
                default: state_nxt = ACCUM;
            endcase
        end
    end

    // Handshake outputs and datapath strobes
    always_comb begin
        in_ready  = (state == ACCUM) && !clear;
        out_valid = (state == HOLD);
        accept    = in_ready && in_valid;
        load      = accept && at_last;
        done      = (state == HOLD) && out_ready && !clear;
    end

    // Burst counter: counts accepts, wraps on the final one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= at_last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sum_acc.sv
// sum_acc: sums bursts of COUNT adder results into an ACC_W total.
// Datapath (accumulator, sticky carry, output registers) lives here.
module sum_acc #(
    parameter int DATA_W = sum_acc_pkg::DATA_W,
    parameter int COUNT  = sum_acc_pkg::COUNT,
    parameter int ACC_W  = sum_acc_pkg::ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf
);
    import sum_acc_pkg::*;

    localparam int EXT_W = ACC_W + 1;

    logic             accept;
    logic             load;
    logic             done;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [EXT_W-1:0] sum_ext;

    sum_acc_ctrl #(
        .COUNT(COUNT)
    ) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .in_valid (in_valid),
        .out_ready(out_ready),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .accept   (accept),
        .load     (load),
        .done     (done)
    );

    // One extra bit so the carry out of ACC_W is visible
    assign sum_ext = {1'b0, acc} + EXT_W'(in_data);

    // Running total and sticky wrap flag for the current burst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (clear || done) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (accept) begin
            acc <= sum_ext[ACC_W-1:0];
            ovf <= ovf | sum_ext[ACC_W];
        end
    end

    // Capture the burst total on the final accept; held through HOLD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_sum <= '0;
            out_ovf <= 1'b0;
        end else if (load) begin
            out_sum <= sum_ext[ACC_W-1:0];
            out_ovf <= ovf | sum_ext[ACC_W];
        end
    end

endmodule

// File: tb/tb_sum_acc.sv
// Self-checking bench for sum_acc.
// Directed bursts with literal expectations plus a randomized run vs a model.
module tb_sum_acc;

    localparam int COUNT = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [5:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_sum;
    logic       out_ovf;

    int checks = 0;
    int errors = 0;

    // Reference model: true integer burst sum, result pending flag
    int m_sum = 0;
    int m_cnt = 0;
    bit m_hold = 1'b0;
    int e_sum = 0;
    bit e_ovf = 1'b0;
    int m_accepts = 0;
    int m_outputs = 0;

    sum_acc dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_ovf  (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model advances on each clock edge from the driven inputs only
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_sum = 0;
            m_cnt = 0;
            m_hold = 1'b0;
            e_sum = 0;
            e_ovf = 1'b0;
        end else if (clear) begin
            m_sum = 0;
            m_cnt = 0;
            m_hold = 1'b0;
        end else if (m_hold) begin
            if (out_ready) begin
                m_hold = 1'b0;
                m_outputs++;
            end
        end else if (in_valid) begin
            m_sum += int'(in_data);
            m_cnt++;
            m_accepts++;
            if (m_cnt == COUNT) begin
                e_sum = m_sum % 256;
                e_ovf = (m_sum > 255);
                m_hold = 1'b1;
                m_sum = 0;
                m_cnt = 0;
            end
        end
    end

    // Compare every cycle on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            chk("out_valid", int'(out_valid), int'(m_hold));
            chk("in_ready", int'(in_ready), int'(!m_hold && !clear));
            if (m_hold && out_valid) begin
                chk("out_sum", int'(out_sum), e_sum);
                chk("out_ovf", int'(out_ovf), int'(e_ovf));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int v, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data = 6'(v);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic take_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        int cycles;

        #2;
        chk("rst_sum", int'(out_sum), 0);
        chk("rst_ovf", int'(out_ovf), 0);
        chk("rst_valid", int'(out_valid), 0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);

        // Plain accumulate
        feed(1, 8);
        chk("acc_valid", int'(out_valid), 1);
        chk("acc_sum", int'(out_sum), 8);
        chk("acc_ovf", int'(out_ovf), 0);
        take_out();

        // Wrap and sticky carry, then a clean burst
        feed(63, 8);
        chk("ovf_sum", int'(out_sum), 248);
        chk("ovf_ovf", int'(out_ovf), 1);
        take_out();
        feed(0, 8);
        chk("zero_sum", int'(out_sum), 0);
        chk("zero_ovf", int'(out_ovf), 0);
        take_out();

        // Backpressure
        feed(5, 8);
        in_valid = 1'b1;
        in_data = 6'd9;
        for (int i = 0; i < 5; i++) begin
            chk("bp_sum", int'(out_sum), 40);
            chk("bp_in_ready", int'(in_ready), 0);
            step();
        end
        in_valid = 1'b0;
        take_out();
        chk("bp_resume", int'(in_ready), 1);

        // Clear mid-burst drops the partial sum
        feed(10, 3);
        clear = 1'b1;
        in_valid = 1'b1;
        in_data = 6'd10;
        #1;
        chk("clr_in_ready", int'(in_ready), 0);
        step();
        clear = 1'b0;
        in_valid = 1'b0;
        feed(2, 8);
        chk("clr_sum", int'(out_sum), 16);
        take_out();

        // Clear during HOLD drops the pending output
        feed(4, 8);
        chk("hold_valid", int'(out_valid), 1);
        clear = 1'b1;
        out_ready = 1'b1;
        step();
        clear = 1'b0;
        out_ready = 1'b0;
        chk("hold_clr_valid", int'(out_valid), 0);

        // Async reset mid-burst
        feed(7, 4);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_sum", int'(out_sum), 0);
        chk("arst_ovf", int'(out_ovf), 0);
        chk("arst_valid", int'(out_valid), 0);
        step();
        rst = 1'b0;
        step();
        feed(3, 8);
        chk("arst_burst", int'(out_sum), 24);
        take_out();

        // Randomized traffic against the model
        cycles = 0;
        m_accepts = 0;
        m_outputs = 0;
        while (m_accepts < 1000 && cycles < 20000) begin
            in_valid = ($urandom % 4) != 0;
            in_data = 6'($urandom);
            out_ready = ($urandom % 3) != 0;
            clear = ($urandom % 64) == 0;
            step();
            cycles++;
        end
        in_valid = 1'b0;
        clear = 1'b0;
        out_ready = 1'b0;
        chk("rand_budget", int'(m_accepts >= 1000), 1);
        chk("rand_outputs", int'(m_outputs > 100), 1);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
